// File: rtl/slot_spi_pkg.sv
// Shared opcode encoding and default widths for the slot-machine SPI command decoder.
package slot_spi_pkg;

    localparam int DEF_FRAME_W     = 16;
    localparam int DEF_OPC_W       = 4;
    localparam int DEF_NUM_REELS   = 3;
    localparam int DEF_REEL_W      = 4;
    localparam int DEF_CRED_W      = 12;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [DEF_OPC_W-1:0] {
        OPC_NOP   = 4'd0,
        OPC_SPIN  = 4'd1,
        OPC_WIN   = 4'd2,
        OPC_TOTAL = 4'd3
    } opc_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with single-cycle rise/fall pulses
// derived from the synchronised level.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Clearing to 0 means a pin already low when reset releases never produces a
    // fall, so a frame interrupted by reset cannot be re-armed half way through.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/spi_frame_decoder.sv
// Oversampled mode-0 SPI target: decodes fixed-length command frames into reel, win and
// total-credit controls, and returns {last opcode, frame count} on sdo during each frame.
module spi_frame_decoder
    import slot_spi_pkg::*;
#(
    parameter int FRAME_W     = DEF_FRAME_W,
    parameter int OPC_W       = DEF_OPC_W,
    parameter int NUM_REELS   = DEF_NUM_REELS,
    parameter int REEL_W      = DEF_REEL_W,
    parameter int CRED_W      = DEF_CRED_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          sclk,
    input  logic                          cs,
    input  logic                          copi,
    output logic                          sdo,
    output logic [NUM_REELS*REEL_W-1:0]   reel_idx,
    output logic                          start_spin,
    output logic [CRED_W-1:0]             win_credits,
    output logic                          is_win,
    output logic [CRED_W-1:0]             total_credits,
    output logic                          is_total,
    output logic                          frame_err
);

    localparam int PAY_W     = FRAME_W - OPC_W;
    localparam int REEL_BITS = NUM_REELS * REEL_W;
    localparam int CNT_W     = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

    logic sclk_lvl_unused;
    logic sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic copi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (sclk),
        .sync_o  (sclk_lvl_unused),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (cs),
        .sync_o  (cs_s),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    logic [SYNC_STAGES-1:0] copi_sync_q;

    always_ff @(posedge clk) begin
        if (!reset_n) copi_sync_q <= '0;
        else          copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
    end

    assign copi_s = copi_sync_q[SYNC_STAGES-1];

    logic                 armed_q,       armed_d;
    logic                 pend_q,        pend_d;
    logic [CNT_W-1:0]     bit_cnt_q,     bit_cnt_d;
    logic [FRAME_W-1:0]   rx_sr_q,       rx_sr_d;
    logic [FRAME_W-1:0]   resp_sr_q,     resp_sr_d;
    logic                 sdo_q,         sdo_d;
    logic [PAY_W-1:0]     frame_cnt_q,   frame_cnt_d;
    logic [OPC_W-1:0]     last_opc_q,    last_opc_d;
    logic [REEL_BITS-1:0] reel_q,        reel_d;
    logic [CRED_W-1:0]    win_q,         win_d;
    logic [CRED_W-1:0]    total_q,       total_d;
    logic                 start_spin_q,  start_spin_d;
    logic                 is_win_q,      is_win_d;
    logic                 is_total_q,    is_total_d;
    logic                 frame_err_q,   frame_err_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            armed_q      <= 1'b0;
            pend_q       <= 1'b0;
            bit_cnt_q    <= '0;
            rx_sr_q      <= '0;
            resp_sr_q    <= '0;
            sdo_q        <= 1'b0;
            frame_cnt_q  <= '0;
            last_opc_q   <= '0;
            reel_q       <= '0;
            win_q        <= '0;
            total_q      <= '0;
            start_spin_q <= 1'b0;
            is_win_q     <= 1'b0;
            is_total_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            armed_q      <= armed_d;
            pend_q       <= pend_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_sr_q      <= rx_sr_d;
            resp_sr_q    <= resp_sr_d;
            sdo_q        <= sdo_d;
            frame_cnt_q  <= frame_cnt_d;
            last_opc_q   <= last_opc_d;
            reel_q       <= reel_d;
            win_q        <= win_d;
            total_q      <= total_d;
            start_spin_q <= start_spin_d;
            is_win_q     <= is_win_d;
            is_total_q   <= is_total_d;
            frame_err_q  <= frame_err_d;
        end
    end

    logic [OPC_W-1:0]   opc;
    logic [PAY_W-1:0]   payload;
    logic [FRAME_W-1:0] resp_load;

    assign opc       = rx_sr_q[FRAME_W-1 -: OPC_W];
    assign payload   = rx_sr_q[PAY_W-1:0];
    assign resp_load = {last_opc_q, frame_cnt_q};

    // Serial side: cs edges take priority, so an sclk edge landing in the same
    // cycle as a cs edge is dropped.
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        armed_d   = armed_q;
        pend_d    = 1'b0;
        bit_cnt_d = bit_cnt_q;
        rx_sr_d   = rx_sr_q;
        resp_sr_d = resp_sr_q;
        sdo_d     = sdo_q;

        if (cs_fall) begin
            armed_d   = 1'b1;
            bit_cnt_d = '0;
            resp_sr_d = resp_load;
            sdo_d     = resp_load[FRAME_W-1];
        end else if (cs_s) begin
            sdo_d = 1'b0;
            if (cs_rise && armed_q) begin
                armed_d = 1'b0;
                pend_d  = 1'b1;
            end
        end else if (armed_q) begin
            if (sclk_rise) begin
                rx_sr_d = {rx_sr_q[FRAME_W-2:0], copi_s};
                if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
            // Zeros shift in behind the response, so sdo idles at 0 once it is spent.
            if (sclk_fall) begin
                resp_sr_d = {resp_sr_q[FRAME_W-2:0], 1'b0};
                sdo_d     = resp_sr_q[FRAME_W-2];
            end
        end
    end

    logic frame_ok;

    // Decode runs one cycle after an armed cs rise, on the captured frame.
    always_comb begin
        frame_ok     = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        last_opc_d   = last_opc_q;
        reel_d       = reel_q;
        win_d        = win_q;
        total_d      = total_q;
        start_spin_d = 1'b0;
        is_win_d     = 1'b0;
        is_total_d   = 1'b0;
        frame_err_d  = 1'b0;

        if (pend_q) begin
            if (bit_cnt_q != CNT_FULL) begin
                frame_err_d = 1'b1;
            end else begin
                case (opc)
                    OPC_W'(OPC_NOP): begin
                        frame_ok = 1'b1;
                    end
                    OPC_W'(OPC_SPIN): begin
                        frame_ok     = 1'b1;
                        reel_d       = payload[REEL_BITS-1:0];
                        start_spin_d = 1'b1;
                    end
                    OPC_W'(OPC_WIN): begin
                        frame_ok = 1'b1;
                        win_d    = payload[CRED_W-1:0];
                        is_win_d = 1'b1;
                    end
                    OPC_W'(OPC_TOTAL): begin
                        frame_ok   = 1'b1;
                        total_d    = payload[CRED_W-1:0];
                        is_total_d = 1'b1;
                    end
                    default: begin
                        frame_err_d = 1'b1;
                    end
                endcase
            end
            if (frame_ok) begin
                last_opc_d  = opc;
                frame_cnt_d = frame_cnt_q + PAY_W'(1);
            end
        end
    end

    assign sdo           = sdo_q;
    assign reel_idx      = reel_q;
    assign start_spin    = start_spin_q;
    assign win_credits   = win_q;
    assign is_win        = is_win_q;
    assign total_credits = total_q;
    assign is_total      = is_total_q;
    assign frame_err     = frame_err_q;

endmodule
